psum_pad_scheduler: RTL and testbench

//  Sequences the PE partial-sum pad (PPAD) through accumulate and drain phases for one PE pass.

---
 rtl/psum_pad_scheduler_if.sv | 38 +++
 rtl/psum_pad_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_psum_pad_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_pad_scheduler_if.sv
// PPAD scheduler channel bundle: issue tokens, write-backs,
// pad read/write strobes and the drained psum handshake.
interface psum_pad_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          o_Iss_rdy;
  logic          i_Iss_ack;
  logic [AW-1:0] o_iss_addr;
  logic          o_iss_first;
  logic          o_iss_last;
  logic          o_pp_read;
  logic [AW-1:0] o_pp_raddr;
  logic          i_Wb_rdy;
  logic          o_Wb_ack;
  logic [AW-1:0] i_wb_addr;
  logic          o_pp_write;
  logic [AW-1:0] o_pp_waddr;
  logic          o_Psum_rdy;
  logic          i_Psum_ack;

  modport master (
    output o_Iss_rdy, o_iss_addr, o_iss_first, o_iss_last,
    output o_pp_read, o_pp_raddr,
    output o_Wb_ack, o_pp_write, o_pp_waddr,
    output o_Psum_rdy,
    input  i_Iss_ack, i_Wb_rdy, i_wb_addr, i_Psum_ack
  );

  modport slave (
    input  o_Iss_rdy, o_iss_addr, o_iss_first, o_iss_last,
    input  o_pp_read, o_pp_raddr,
    input  o_Wb_ack, o_pp_write, o_pp_waddr,
    input  o_Psum_rdy,
    output i_Iss_ack, i_Wb_rdy, i_wb_addr, i_Psum_ack
  );
endinterface

// File: rtl/psum_pad_scheduler.sv
// PPAD accumulate/drain sequencer. Ports: i_clk/i_rstn, start+config,
// busy/done/err status, and the pif channel bundle (master side).
module psum_pad_scheduler #(
  parameter  int DEPTH = 16,
  parameter  int RW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [AW:0]   i_nword,
  input  logic [RW-1:0] i_nround,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  psum_pad_scheduler_if.master pif
);

  typedef enum logic [2:0] {
    IDLE, ACCUM, FLUSH, DRAIN, DONE
  } state_t;

  state_t         state, state_n;
  logic [AW:0]    nword_q, nword_n;
  logic [RW-1:0]  nround_q, nround_n;
  logic [RW-1:0]  round_q, round_n;
  logic [AW-1:0]  addr_q, addr_n;
  logic [AW-1:0]  raddr_q, raddr_n;
  logic [DEPTH-1:0] sb_q, sb_n;
  logic           err_q, err_n;
  logic           vld_q, vld_n;
  logic           rdall_q, rdall_n;

  logic          iss_rdy, iss_first, iss_last;
  logic [AW-1:0] iss_addr, pp_raddr;
  logic          pp_read, psum_rdy, done;
  logic          wb_ack, wb_fire, iss_fire, rd_en;
  logic          wrap;

  assign wrap = ({1'b0, addr_q} == nword_q - (AW+1)'(1));

  always_comb begin
    state_n   = state;
    nword_n   = nword_q;
    nround_n  = nround_q;
    round_n   = round_q;
    addr_n    = addr_q;
    raddr_n   = raddr_q;
    sb_n      = sb_q;
    err_n     = err_q;
    vld_n     = vld_q;
    rdall_n   = rdall_q;
    iss_rdy   = 1'b0;
    iss_first = 1'b0;
    iss_last  = 1'b0;
    iss_addr  = '0;
    pp_read   = 1'b0;
    pp_raddr  = '0;
    psum_rdy  = 1'b0;
    done      = 1'b0;
    iss_fire  = 1'b0;
    rd_en     = 1'b0;

    wb_ack  = (state == ACCUM) || (state == FLUSH);
    wb_fire = wb_ack && pif.i_Wb_rdy;
    // clear first so a set of the same address below wins
    if (wb_fire) begin
      if (!sb_q[pif.i_wb_addr]) err_n = 1'b1;
      sb_n[pif.i_wb_addr] = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (i_start) begin
          nword_n  = i_nword;
          nround_n = i_nround;
          round_n  = '0;
          addr_n   = '0;
          raddr_n  = '0;
          sb_n     = '0;
          err_n    = 1'b0;
          vld_n    = 1'b0;
          rdall_n  = 1'b0;
          if (i_nword == '0)       state_n = DONE;
          else if (i_nround == '0) state_n = DRAIN;
          else                     state_n = ACCUM;
        end
      end
      ACCUM: begin
        iss_addr  = addr_q;
        iss_first = (round_q == '0);
        iss_last  = wrap && (round_q == nround_q - RW'(1));
        // registered sb only: no bypass of same-cycle write-back
        iss_rdy   = !sb_q[addr_q];
        iss_fire  = iss_rdy && pif.i_Iss_ack;
        if (iss_fire) begin
          pp_read      = !iss_first;
          pp_raddr     = addr_q;
          sb_n[addr_q] = 1'b1;
          if (wrap) begin
            addr_n  = '0;
            round_n = round_q + RW'(1);
          end else begin
            addr_n  = addr_q + AW'(1);
          end
          if (iss_last) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (sb_q == '0) begin
          state_n = DRAIN;
          addr_n  = '0;
          vld_n   = 1'b0;
          rdall_n = 1'b0;
        end
      end
      DRAIN: begin
        psum_rdy = vld_q;
        pp_raddr = raddr_q;
        // refill the slot when empty or emptying this cycle
        rd_en = !rdall_q && (!vld_q || pif.i_Psum_ack);
        if (rd_en) begin
          pp_read  = 1'b1;
          pp_raddr = addr_q;
          raddr_n  = addr_q;
          vld_n    = 1'b1;
          if (wrap) rdall_n = 1'b1;
          else      addr_n  = addr_q + AW'(1);
        end else if (vld_q && pif.i_Psum_ack) begin
          vld_n = 1'b0;
          if (rdall_q) state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      nword_q  <= '0;
      nround_q <= '0;
      round_q  <= '0;
      addr_q   <= '0;
      raddr_q  <= '0;
      sb_q     <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      rdall_q  <= 1'b0;
    end else begin
      state    <= state_n;
      nword_q  <= nword_n;
      nround_q <= nround_n;
      round_q  <= round_n;
      addr_q   <= addr_n;
      raddr_q  <= raddr_n;
      sb_q     <= sb_n;
      err_q    <= err_n;
      vld_q    <= vld_n;
      rdall_q  <= rdall_n;
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = done;
  assign o_err  = err_q;

  assign pif.o_Iss_rdy   = iss_rdy;
  assign pif.o_iss_addr  = iss_addr;
  assign pif.o_iss_first = iss_first;
  assign pif.o_iss_last  = iss_last;
  assign pif.o_pp_read   = pp_read;
  assign pif.o_pp_raddr  = pp_raddr;
  assign pif.o_Wb_ack    = wb_ack;
  assign pif.o_pp_write  = wb_fire;
  assign pif.o_pp_waddr  = pif.i_wb_addr;
  assign pif.o_Psum_rdy  = psum_rdy;

endmodule

// File: tb/tb_psum_pad_scheduler.sv
// Directed bench for psum_pad_scheduler: table of whole passes
// plus hand sequences for err, ignored start and mid-pass reset.
module tb_psum_pad_scheduler;
  localparam int DEPTH = 16;
  localparam int RW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   nword = '0;
  logic [RW-1:0] nround = '0;
  logic          busy, done, err;

  psum_pad_scheduler_if #(.DEPTH(DEPTH)) pif();

  psum_pad_scheduler #(.DEPTH(DEPTH), .RW(RW)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_start  (start),
    .i_nword  (nword),
    .i_nround (nround),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .pif      (pif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nw; int nr; int dly; bit tog;
    int e_iss; int e_first; int e_rd; int e_last;
    bit stall;
  } vec_t;

  vec_t tbl[8];

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  bit iss_en, tog, model_en, man_wb;
  int dly, man_wb_addr;
  int wq_addr[$];
  int wq_due[$];
  int iss_cyc[$];
  int n_iss, n_first, n_last, n_rdacc, n_wr, n_drain, n_done;
  int drain_bad, hold_bad;
  int done_cyc, first_ps_cyc, last_ps_cyc, first_wb_cyc, start_cyc;
  int rdy_at_wb, cap_write, cap_waddr, pad_q, hold_data;
  bit hold_pend;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clr_stats();
    wq_addr.delete(); wq_due.delete(); iss_cyc.delete();
    n_iss = 0; n_first = 0; n_last = 0; n_rdacc = 0;
    n_wr = 0; n_drain = 0; n_done = 0;
    drain_bad = 0; hold_bad = 0; hold_pend = 0;
    done_cyc = -1; first_ps_cyc = -1; last_ps_cyc = -1;
    first_wb_cyc = -1; rdy_at_wb = -1; man_wb = 0;
  endtask

  // one clock: drive at negedge, observe #1 later, then cross posedge
  task automatic step();
    bit rd;
    int ra;
    pif.i_Iss_ack  = iss_en;
    pif.i_Psum_ack = tog ? (cyc % 2 == 0) : 1'b1;
    pif.i_Wb_rdy   = 1'b0;
    pif.i_wb_addr  = '0;
    if (man_wb) begin
      pif.i_Wb_rdy  = 1'b1;
      pif.i_wb_addr = AW'(man_wb_addr);
    end else if (model_en && wq_due.size() > 0) begin
      if (wq_due[0] <= cyc) begin
        pif.i_Wb_rdy  = 1'b1;
        pif.i_wb_addr = AW'(wq_addr[0]);
      end
    end
    #1;
    if (pif.o_Iss_rdy && pif.i_Iss_ack) begin
      n_iss++;
      if (pif.o_iss_first) n_first++;
      if (pif.o_iss_last)  n_last++;
      if (pif.o_pp_read)   n_rdacc++;
      iss_cyc.push_back(cyc);
      if (model_en) begin
        wq_addr.push_back(int'(pif.o_iss_addr));
        wq_due.push_back(cyc + dly);
      end
    end
    cap_write = pif.o_pp_write;
    cap_waddr = pif.o_pp_waddr;
    if (pif.i_Wb_rdy && pif.o_Wb_ack) begin
      n_wr++;
      if (!man_wb) begin
        void'(wq_addr.pop_front());
        void'(wq_due.pop_front());
      end
      if (first_wb_cyc < 0) begin
        first_wb_cyc = cyc;
        rdy_at_wb = pif.o_Iss_rdy;
      end
    end
    if (hold_pend) begin
      if (!pif.o_Psum_rdy || pad_q != hold_data) hold_bad++;
      if (!pif.i_Psum_ack && pif.o_pp_read) hold_bad++;
    end
    hold_pend = pif.o_Psum_rdy && !pif.i_Psum_ack;
    hold_data = pad_q;
    if (pif.o_Psum_rdy && pif.i_Psum_ack) begin
      if (pad_q != n_drain) drain_bad++;
      if (n_drain == 0) first_ps_cyc = cyc;
      last_ps_cyc = cyc;
      n_drain++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    rd = pif.o_pp_read;
    ra = pif.o_pp_raddr;
    @(posedge clk);
    if (rd) pad_q = ra;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (n_done > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_pass(vec_t v, string tag);
    bit ok;
    int rf;
    clr_stats();
    dly = v.dly; tog = v.tog;
    iss_en = 1; model_en = 1;
    nword  = v.nw[AW:0];
    nround = v.nr[RW-1:0];
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    run_to_done(ok);
    chk({tag, " timeout"}, ok, 1);
    chk({tag, " issues"}, n_iss, v.e_iss);
    chk({tag, " first"}, n_first, v.e_first);
    chk({tag, " acc_reads"}, n_rdacc, v.e_rd);
    chk({tag, " last"}, n_last, v.e_last);
    chk({tag, " writes"}, n_wr, v.e_iss);
    chk({tag, " drains"}, n_drain, v.nw);
    chk({tag, " drain_order"}, drain_bad, 0);
    chk({tag, " psum_hold"}, hold_bad, 0);
    chk({tag, " err"}, err, 0);
    rf = (v.nw > 0) ? last_ps_cyc : start_cyc;
    chk({tag, " done_lat"}, done_cyc - rf, 1);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
    if (!v.tog && v.nw > 0)
      chk({tag, " drain_span"}, last_ps_cyc - first_ps_cyc, v.nw - 1);
    if (v.stall) begin
      chk({tag, " stall_rdy"}, rdy_at_wb, 0);
      chk({tag, " stall_iss"}, iss_cyc[v.nw], first_wb_cyc + 1);
    end
  endtask

  initial begin
    bit ok;
    vec_t v;
    tbl[0] = '{4, 1, 3, 1'b0, 4, 4, 0, 1, 1'b0};
    tbl[1] = '{2, 3, 5, 1'b0, 6, 2, 4, 1, 1'b1};
    tbl[2] = '{16, 2, 1, 1'b0, 32, 16, 16, 1, 1'b0};
    tbl[3] = '{1, 4, 1, 1'b0, 4, 1, 3, 1, 1'b1};
    tbl[4] = '{3, 0, 2, 1'b0, 0, 0, 0, 0, 1'b0};
    tbl[5] = '{0, 5, 2, 1'b0, 0, 0, 0, 0, 1'b0};
    tbl[6] = '{4, 1, 2, 1'b1, 4, 4, 0, 1, 1'b0};
    tbl[7] = '{5, 2, 4, 1'b1, 10, 5, 5, 1, 1'b0};

    pif.i_Iss_ack = 1'b0; pif.i_Wb_rdy = 1'b0;
    pif.i_wb_addr = '0;   pif.i_Psum_ack = 1'b0;
    pad_q = 0; iss_en = 0; tog = 0; model_en = 0; dly = 1;
    clr_stats();

    repeat (2) @(negedge clk);
    chk("reset ctl", int'({busy, done, err, pif.o_Iss_rdy,
        pif.o_Wb_ack, pif.o_pp_read, pif.o_pp_write,
        pif.o_Psum_rdy, pif.o_iss_first, pif.o_iss_last}), 0);
    chk("reset addr", int'({pif.o_iss_addr, pif.o_pp_raddr,
        pif.o_pp_waddr}), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_pass(tbl[i], $sformatf("v%0d", i));

    // bogus write-back, sticky err, start ignored while busy
    clr_stats();
    tog = 0; iss_en = 0; model_en = 1; dly = 2;
    nword = 5'd2; nround = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    man_wb = 1; man_wb_addr = 3;
    step();
    man_wb = 0;
    chk("bogus write", cap_write, 1);
    chk("bogus waddr", cap_waddr, 3);
    chk("err set", err, 1);
    step();
    chk("err sticky", err, 1);
    nword = 5'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("start ignored busy", busy, 1);
    chk("start ignored done", n_done, 0);
    iss_en = 1;
    run_to_done(ok);
    chk("err pass timeout", ok, 1);
    chk("err pass issues", n_iss, 2);
    chk("err pass writes", n_wr, 3);
    chk("err after done", err, 1);
    v = '{1, 1, 1, 1'b0, 1, 1, 0, 1, 1'b0};
    run_pass(v, "err_clear");

    // reset in the middle of ACCUM
    clr_stats();
    tog = 0; iss_en = 1; model_en = 1; dly = 3;
    nword = 5'd4; nround = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    man_wb = 1; man_wb_addr = 9;
    step();
    man_wb = 0;
    step(); step();
    chk("pre reset err", err, 1);
    chk("pre reset busy", busy, 1);
    chk("pre reset issued", n_iss, 3);
    pif.i_Wb_rdy = 1'b0;
    pif.i_wb_addr = '0;
    #2 rstn = 1'b0;
    #1;
    chk("mid reset ctl", int'({busy, done, err, pif.o_Iss_rdy,
        pif.o_Wb_ack, pif.o_pp_read, pif.o_pp_write,
        pif.o_Psum_rdy, pif.o_iss_first, pif.o_iss_last}), 0);
    chk("mid reset addr", int'({pif.o_iss_addr, pif.o_pp_raddr,
        pif.o_pp_waddr}), 0);
    @(negedge clk);
    rstn = 1'b1;
    v = '{2, 2, 1, 1'b0, 4, 2, 2, 1, 1'b0};
    run_pass(v, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
